// File: rtl/la_capture_ctrl.sv
// -----------------------------------------------------------------------------
// la_capture_ctrl
//   Sequencer for a logic-analyser capture buffer. It drives the companion
//   write/read address generator so that, once the buffer is full, the read
//   pointer sits pre_depth samples before the trigger point.
//
//   Optional feature (macro LA_AUTO_TRIG_EN): auto-trigger after AUTO_TRIG_CYC
//   cycles in ARMED without a trigger; trig_auto flags that it happened.
//
// Ports
//   nrst      async active-low reset
//   clk       clock
//   start     pulse: arm (or restart) a capture
//   stop      pulse: abort / end capture, wins over start
//   trig      trigger strobe, honoured only in ARMED
//   wr_inc    sample strobe shared with the address generator
//   pre_depth pre-trigger sample count (1 .. 2^ADDR_W-2048)
//   wr_end    buffer-full flag, honoured only in POST / DONE
//   rd_req    host read-advance strobe (DONE only)
//   wr_en     write enable to the address generator
//   load_w2r  copy write address into read address
//   rd_inc    apply rd_step to the read address
//   rd_step   signed 8-bit read-address step
//   busy      capture in progress (not IDLE / DONE)
//   done      capture complete, buffer readable
//   trig_auto capture was triggered by timeout
//   state     current state encoding
// -----------------------------------------------------------------------------
module la_capture_ctrl #(
   parameter int ADDR_W        = 18,
   parameter int AUTO_TRIG_CYC = 1000000
) (
   input  logic              nrst,
   input  logic              clk,
   input  logic              start,
   input  logic              stop,
   input  logic              trig,
   input  logic              wr_inc,
   input  logic [ADDR_W-1:0] pre_depth,
   input  logic              wr_end,
   input  logic              rd_req,
   output logic              wr_en,
   output logic              load_w2r,
   output logic              rd_inc,
   output logic [7:0]        rd_step,
   output logic              busy,
   output logic              done,
   output logic              trig_auto,
   output logic [2:0]        state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLR0  = 3'd1,
      CLR1  = 3'd2,
      PRE   = 3'd3,
      ARMED = 3'd4,
      ADJ   = 3'd5,
      POST  = 3'd6,
      DONE  = 3'd7
   } state_t;

   state_t            st;
   logic [ADDR_W-1:0] cnt;      // pre-fill sample counter
   logic [ADDR_W-1:0] rem;      // remaining backward read adjustment
   logic [ADDR_W-1:0] depth_q;  // pre_depth as seen during PRE
   logic              adj_big;
   logic [ADDR_W-1:0] adj_amt;
   logic              pre_hit;
   logic              trig_eff;
   logic              to_hit;

   assign state   = st;
   assign adj_big = (rem >= ADDR_W'(128));
   assign adj_amt = adj_big ? ADDR_W'(128) : rem;
   // count reaches pre_depth on this sample
   assign pre_hit = wr_inc && (cnt >= pre_depth - ADDR_W'(1));

`ifdef LA_AUTO_TRIG_EN
   localparam int TO_W = $clog2(AUTO_TRIG_CYC + 1);
   logic [TO_W-1:0] to_cnt;
   assign to_hit = (to_cnt == TO_W'(AUTO_TRIG_CYC - 1));
`else
   logic unused_cfg;
   assign unused_cfg = (AUTO_TRIG_CYC == 0);
   assign to_hit     = 1'b0;
   assign trig_auto  = 1'b0;
`endif

   assign trig_eff = trig | to_hit;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         st      <= IDLE;
         cnt     <= '0;
         rem     <= '0;
         depth_q <= '0;
`ifdef LA_AUTO_TRIG_EN
         to_cnt    <= '0;
         trig_auto <= 1'b0;
`endif
      end else if (stop) begin
         st <= IDLE;
      end else if (start) begin
         st <= CLR0;
`ifdef LA_AUTO_TRIG_EN
         trig_auto <= 1'b0;
`endif
      end else begin
         case (st)
            CLR0: st <= CLR1;
            CLR1: begin
               cnt <= '0;
               st  <= PRE;
            end
            PRE: begin
               depth_q <= pre_depth;
               if (wr_inc && cnt < pre_depth) cnt <= cnt + ADDR_W'(1);
               if (pre_hit) begin
                  st <= ARMED;
`ifdef LA_AUTO_TRIG_EN
                  to_cnt <= '0;
`endif
               end
            end
            ARMED: begin
               if (trig_eff) begin
                  st  <= ADJ;
                  rem <= depth_q - ADDR_W'(1);
`ifdef LA_AUTO_TRIG_EN
                  if (!trig) trig_auto <= 1'b1;
`endif
               end
`ifdef LA_AUTO_TRIG_EN
               else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
`endif
            end
            ADJ: begin
               if (rem == '0) st <= POST;
               else           rem <= rem - adj_amt;
            end
            POST: if (wr_end) st <= DONE;
            default: ;  // IDLE waits for start, DONE holds until start/stop
         endcase
      end
   end

   always_comb begin
      wr_en    = 1'b0;
      load_w2r = 1'b0;
      rd_inc   = 1'b0;
      rd_step  = 8'h00;
      busy     = (st != IDLE) && (st != DONE);
      done     = (st == DONE);
      case (st)
         CLR0: load_w2r = 1'b1;
         CLR1: begin
            rd_inc  = 1'b1;
            rd_step = 8'hFF;
         end
         PRE, ARMED: begin
            // read pointer tracks one behind the write pointer
            wr_en   = 1'b1;
            rd_inc  = wr_inc;
            rd_step = 8'h01;
         end
         ADJ: begin
            wr_en = 1'b1;
            if (rem != '0) begin
               rd_inc  = 1'b1;
               rd_step = adj_big ? 8'h80 : (8'h00 - rem[7:0]);
            end
         end
         POST: wr_en = 1'b1;
         DONE: begin
            // keep writing enabled so wr_end stays latched in the generator
            wr_en   = 1'b1;
            rd_inc  = rd_req;
            rd_step = 8'h01;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_la_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_la_capture_ctrl
//   Directed bench for la_capture_ctrl: reset, short and long pre-trigger
//   captures, ignored trig/wr_end, stop/start collision, restart, minimum
//   pre_depth, asynchronous reset mid-capture, and (with LA_AUTO_TRIG_EN)
//   the auto-trigger timeout.
// -----------------------------------------------------------------------------
module tb_la_capture_ctrl;

`ifdef LA_AUTO_TRIG_EN
   localparam int ATC = 16;
`else
   localparam int ATC = 1000000;
`endif
   localparam int AW = 18;

   logic          nrst, clk, start, stop, trig, wr_inc, wr_end, rd_req;
   logic [AW-1:0] pre_depth;
   logic          wr_en, load_w2r, rd_inc, busy, done, trig_auto;
   logic [7:0]    rd_step;
   logic [2:0]    state;

   int errors = 0;
   int checks = 0;
   int pulses;

   la_capture_ctrl #(.ADDR_W(AW), .AUTO_TRIG_CYC(ATC)) dut (
      .nrst(nrst), .clk(clk), .start(start), .stop(stop), .trig(trig),
      .wr_inc(wr_inc), .pre_depth(pre_depth), .wr_end(wr_end), .rd_req(rd_req),
      .wr_en(wr_en), .load_w2r(load_w2r), .rd_inc(rd_inc), .rd_step(rd_step),
      .busy(busy), .done(done), .trig_auto(trig_auto), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one edge, then settle away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // start a capture from the current state and walk into PRE
   task automatic arm(input logic [AW-1:0] depth);
      pre_depth = depth;
      start = 1'b1; tick(); start = 1'b0; #1;
      chk("clr0_state", state, 3'd1);
      chk("clr0_load",  load_w2r, 1'b1);
      chk("clr0_wren",  wr_en, 1'b0);
      chk("clr0_busy",  busy, 1'b1);
      tick();
      chk("clr1_state", state, 3'd2);
      chk("clr1_rdinc", rd_inc, 1'b1);
      chk("clr1_step",  rd_step, 8'hFF);
      chk("clr1_wren",  wr_en, 1'b0);
      tick();
      chk("pre_state",  state, 3'd3);
   endtask

   initial begin
      nrst = 1'b0; start = 1'b0; stop = 1'b0; trig = 1'b0; wr_inc = 1'b0;
      wr_end = 1'b0; rd_req = 1'b0; pre_depth = '0;
      repeat (3) tick();
      chk("rst_state", state, 3'd0);
      nrst = 1'b1;
      repeat (10) tick();
      chk("idle_state",  state, 3'd0);
      chk("idle_wren",   wr_en, 1'b0);
      chk("idle_load",   load_w2r, 1'b0);
      chk("idle_rdinc",  rd_inc, 1'b0);
      chk("idle_busy",   busy, 1'b0);
      chk("idle_done",   done, 1'b0);
      chk("idle_tauto",  trig_auto, 1'b0);

      // ---- pre_depth=5, trig pulse during PRE ignored ----
      wr_inc = 1'b1;
      arm(18'd5);
      for (int i = 0; i < 5; i++) begin
         chk("pre5_state", state, 3'd3);
         chk("pre5_wren",  wr_en, 1'b1);
         chk("pre5_track", {rd_inc, rd_step}, {1'b1, 8'h01});
         trig = (i == 2);
         tick();
      end
      trig = 1'b0; #1;
      chk("armed5_state", state, 3'd4);
      repeat (3) begin
         tick();
         chk("armed5_wait", state, 3'd4);
      end
      trig = 1'b1; #1;
      chk("armed5_track", {rd_inc, rd_step}, {1'b1, 8'h01});
      tick(); trig = 1'b0; #1;
      chk("adj5_state", state, 3'd5);
      chk("adj5_step",  {rd_inc, rd_step}, {1'b1, 8'hFC});
      chk("adj5_wren",  wr_en, 1'b1);
      tick();
      chk("adj5_exit",  {state, rd_inc}, {3'd5, 1'b0});
      tick();
      chk("post5_state", state, 3'd6);
      chk("post5_busy",  busy, 1'b1);
      wr_end = 1'b1;
      tick();
      chk("done5_state", state, 3'd7);
      chk("done5_flags", {done, busy, wr_en, rd_inc}, {1'b1, 1'b0, 1'b1, 1'b0});
      pulses = 0;
      repeat (3) begin
         rd_req = 1'b1; #1;
         chk("done5_rd", {rd_inc, rd_step}, {1'b1, 8'h01});
         if (rd_inc) pulses++;
         tick();
         rd_req = 1'b0; #1;
         chk("done5_rdoff", rd_inc, 1'b0);
         tick();
      end
      chk("done5_pulses", pulses, 3);
      chk("done5_hold", state, 3'd7);

      // ---- pre_depth=300, restart from DONE, wr_end held high (ignored) ----
      arm(18'd300);
      repeat (299) tick();
      chk("pre300_state", state, 3'd3);
      tick();
      chk("armed300_state", state, 3'd4);
      trig = 1'b1; tick(); trig = 1'b0; #1;
      chk("adj300_s0", {rd_inc, rd_step}, {1'b1, 8'h80});
      tick();
      chk("adj300_s1", {rd_inc, rd_step}, {1'b1, 8'h80});
      tick();
      chk("adj300_s2", {rd_inc, rd_step}, {1'b1, 8'hD5});
      tick();
      chk("adj300_exit", {state, rd_inc}, {3'd5, 1'b0});
      wr_end = 1'b0;
      tick();
      chk("post300_state", state, 3'd6);
      stop = 1'b1; start = 1'b1;
      tick();
      stop = 1'b0; start = 1'b0; #1;
      chk("stop_state", state, 3'd0);
      chk("stop_wren",  wr_en, 1'b0);
      chk("stop_busy",  busy, 1'b0);

      // ---- pre_depth=1, no samples stalls PRE, ADJ exits at once ----
      wr_inc = 1'b0;
      arm(18'd1);
      tick(); tick();
      chk("pre1_stall", state, 3'd3);
      chk("pre1_noinc", rd_inc, 1'b0);
      wr_inc = 1'b1;
      tick();
      chk("armed1_state", state, 3'd4);
      trig = 1'b1; tick(); trig = 1'b0; #1;
      chk("adj1_exit", {state, rd_inc, rd_step}, {3'd5, 1'b0, 8'h00});
      tick();
      chk("post1_state", state, 3'd6);
      // async reset mid-capture
      @(negedge clk);
      nrst = 1'b0; #1;
      chk("arst_state", state, 3'd0);
      chk("arst_outs", {wr_en, load_w2r, rd_inc, busy, done}, 5'b0);
      tick();
      nrst = 1'b1;
      tick();
      chk("arst_idle", state, 3'd0);

`ifdef LA_AUTO_TRIG_EN
      // ---- auto-trigger timeout ----
      arm(18'd2);
      tick(); tick();
      for (int i = 0; i < ATC; i++) begin
         chk("auto_armed", state, 3'd4);
         tick();
      end
      chk("auto_adj",   state, 3'd5);
      chk("auto_flag",  trig_auto, 1'b1);
      start = 1'b1; tick(); start = 1'b0; #1;
      chk("auto_clear", {state, trig_auto}, {3'd1, 1'b0});
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/la_capture_ctrl.md
LA_CAPTURE_CTRL -- requirements
Module: la_capture_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, the address width of the companion address generator.
REQ-002 SHALL have parameter AUTO_TRIG_CYC, default 1000000, the auto-trigger timeout in clk cycles (used only under LA_AUTO_TRIG_EN).
REQ-003 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-005 SHALL have port start  input  1  one-cycle pulse that arms a capture.
REQ-006 SHALL have port stop  input  1  one-cycle pulse that aborts or ends a capture.
REQ-007 SHALL have port trig  input  1  trigger event strobe.
REQ-008 SHALL have port wr_inc  input  1  sample strobe, same signal as fed to the address generator.
REQ-009 SHALL have port pre_depth  input  ADDR_W  pre-trigger sample count; legal range 1 to 2^ADDR_W-2048; sampled only in PRE.
REQ-010 SHALL have port wr_end  input  1  buffer-full flag from the address generator.
REQ-011 SHALL have port rd_req  input  1  host read-advance strobe.
REQ-012 SHALL have ports wr_en, load_w2r, rd_inc (output, 1 each) and rd_step (output, 8, signed step) driving the address generator.
REQ-013 SHALL have ports busy, done, trig_auto (output, 1 each) and state (output, 3).

Function
REQ-014 SHALL implement states IDLE=0, CLR0=1, CLR1=2, PRE=3, ARMED=4, ADJ=5, POST=6, DONE=7, held in a register and reflected on state.
REQ-015 SHALL decode outputs combinationally from the state register and inputs; they SHALL be 0 unless stated otherwise below.
REQ-016 IDLE: all outputs 0; start -> CLR0.
REQ-017 CLR0: load_w2r=1, wr_en=0, so read address equals write address and wr_end clears; -> CLR1 unconditionally.
REQ-018 CLR1: rd_inc=1, rd_step=8'hFF (-1), wr_en=0, so read address equals write address - 1; clear pre-fill counter; -> PRE.
REQ-019 PRE: wr_en=1, rd_inc=wr_inc, rd_step=+1, keeping the read address 1 behind the write address; count wr_inc; trig ignored; -> ARMED on the cycle the count reaches pre_depth.
REQ-020 ARMED: outputs as in PRE; trig=1 -> ADJ, loading remainder rem=pre_depth-1; the tracking rd_inc on that cycle still applies.
REQ-021 ADJ: wr_en=1; if rem=0 -> POST with rd_inc=0; otherwise rd_inc=1, rd_step=-min(rem,128) in 8-bit two's complement (8'h80 for 128), rem decrements by the same amount.
REQ-022 ADJ SHALL therefore take ceil((pre_depth-1)/128) cycles, plus 1 cycle for the rem=0 exit.
REQ-023 POST: wr_en=1; wr_end=1 -> DONE; wr_end SHALL be ignored in every state except POST and DONE.
REQ-024 DONE: wr_en=1, held so that wr_end stays latched; done=1; rd_inc=rd_req, rd_step=+1.
REQ-025 busy SHALL be 1 in every state except IDLE and DONE.
REQ-026 stop SHALL force IDLE on the next edge from any state; when stop and start coincide, stop SHALL win.
REQ-027 start in any non-IDLE state (without stop) SHALL restart the capture at CLR0.
REQ-028 The pre-fill counter SHALL be ADDR_W bits, saturating at pre_depth.
REQ-029 Address arithmetic SHALL wrap modulo 2^ADDR_W; the block SHALL NOT special-case wrap.

Reset
REQ-030 nrst=0 SHALL asynchronously set state=IDLE, rem=0, pre-fill counter=0, timeout counter=0 and trig_auto=0.
REQ-031 After reset all outputs SHALL be 0; reset mid-capture SHALL abandon the capture with no further strobes.

Configuration
REQ-032 Macro LA_AUTO_TRIG_EN defined: a counter SHALL clear on ARMED entry and count cycles in ARMED; reaching AUTO_TRIG_CYC without trig SHALL act as trig and set trig_auto=1 until the next CLR0.
REQ-033 Macro LA_AUTO_TRIG_EN undefined: no timeout counter SHALL exist; trig_auto SHALL be tied 0 and ARMED SHALL wait indefinitely.

Verification
REQ-034 Reset, then idle 10 cycles -> state=0, wr_en=load_w2r=rd_inc=0, busy=done=0.
REQ-035 pre_depth=5, start, wr_inc every cycle, trig 3 cycles after ARMED -> PRE lasts 5 samples; ADJ emits one rd_step=8'hFC (-4); DONE after the buffer fills; read address = trigger address - 5.
REQ-036 pre_depth=300 -> ADJ emits steps 8'h80, 8'h80, 8'hD5 (-43), then exits to POST.
REQ-037 stop asserted in POST, with start on the same cycle -> IDLE next cycle, wr_en=0, busy=0.
REQ-038 trig pulsed during PRE -> ignored; state stays PRE until the pre_depth count completes.
REQ-039 LA_AUTO_TRIG_EN with AUTO_TRIG_CYC=16, no trig -> ADJ entered 16 cycles after ARMED, trig_auto=1; in DONE, 3 rd_req pulses -> 3 rd_inc pulses with rd_step=8'h01.
